// File: rtl/cpu_debug_ctrl.sv
// Debug controller between the board switches/buttons and the MIPS core.
// Issues the core clock-enable (halt / step / run / divided run), handles a PC
// breakpoint, debounces the step button, counts retired instructions per
// class and drives a registered 32-bit value to the 7-segment display.
module cpu_debug_ctrl #(
  parameter int PC_WIDTH        = 9,
  parameter int CNT_WIDTH       = 32,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DIV_LOG2        = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          sw_mode,
  input  logic [2:0]          sw_sel,
  input  logic [4:0]          sw_reg,
  input  logic                step_btn,
  input  logic                cpu_rst_btn,
  input  logic                bp_en,
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         instr,
  input  logic [31:0]         reg_data,
  output logic [4:0]          reg_addr,
  output logic                cpu_clk_en,
  output logic                cpu_rst,
  output logic [31:0]         seg_hex,
  output logic [7:0]          led,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {S_HALT = 2'b00, S_STEP = 2'b01, S_RUN = 2'b10, S_BREAK = 2'b11} state_e;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  state_e                      state_q, state_d, mode_st;
  logic                        en_q, en_d, first_q, first_d;
  logic [1:0]                  step_sync_q, rst_sync_q;
  logic                        db_q;
  logic [DB_W-1:0]             db_cnt_q;
  logic [DIV_LOG2-1:0]         div_q;
  logic [CNT_WIDTH-1:0]        ret_cnt_q;
  logic [4:0][CNT_WIDTH-1:0]   cls_cnt_q;
  logic [4:0]                  cls, cls_q;
  logic                        differ, db_flip, step_req, kill;
  logic [31:0]                 seg_d;

  assign reg_addr  = sw_reg;
  assign cpu_rst   = rst_sync_q[1];
  assign dbg_state = state_q;
  assign led       = {~state_q[1], state_q == S_RUN, state_q == S_BREAK, cls_q};

  // Two-flop synchronisers for both raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync_q <= '0;
      rst_sync_q  <= '0;
    end else begin
      step_sync_q <= {step_sync_q[0], step_btn};
      rst_sync_q  <= {rst_sync_q[0], cpu_rst_btn};
    end
  end

  // Debounce: flip the level once the input has disagreed for DEBOUNCE_CYCLES
  // cycles; the flip is taken in the cycle the count is already full so the
  // step enable can be registered straight out of it.
  assign differ   = step_sync_q[1] ^ db_q;
  assign db_flip  = differ && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES));
  assign step_req = db_flip && step_sync_q[1];

  // Debounce counter and level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (!differ || db_flip) begin
      db_cnt_q <= '0;
      db_q     <= db_q ^ db_flip;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  // Free-running rate divider for divided run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       div_q <= '0;
    else if (cpu_rst) div_q <= '0;
    else              div_q <= div_q + 1'b1;
  end

  // The enable is registered one cycle ahead, but the core's PC only settles
  // after the previous enable, so the breakpoint is checked against the PC
  // present in the enable cycle itself and kills that enable.
  assign kill       = (state_q == S_RUN) && en_q && bp_en && (pc == bp_addr) && !first_q;
  assign cpu_clk_en = en_q && !kill && !cpu_rst;
  assign mode_st    = sw_mode[1] ? S_RUN : state_e'({1'b0, sw_mode[0]});

  // Next-state and next-enable logic; a mode change always beats a step
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    first_d = first_q;
    if (cpu_rst) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_HALT: state_d = mode_st;
        S_STEP:
          if (mode_st != S_STEP) state_d = mode_st;
          else                   en_d = step_req;
        S_RUN:
          if (!sw_mode[1]) state_d = mode_st;
          else if (kill)   state_d = S_BREAK;
          else             en_d = sw_mode[0] ? (&div_q) : 1'b1;
        default:
          if (!sw_mode[1]) state_d = mode_st;
          else             en_d = step_req;
      endcase
    end
    if (state_d == S_RUN && state_q != S_RUN) first_d = 1'b1;
    else if (cpu_clk_en && state_q == S_RUN)  first_d = 1'b0;
  end

  // FSM state, enable and resume flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALT;
      en_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      first_q <= first_d;
    end
  end

  // One-hot opcode class: R, LW, SW, BEQ, J (all zero for anything else)
  always_comb begin
    cls = 5'b0;
    case (instr[31:26])
      6'b000000: cls = 5'b00001;
      6'b100011: cls = 5'b00010;
      6'b101011: cls = 5'b00100;
      6'b000100: cls = 5'b01000;
      6'b000010: cls = 5'b10000;
      default:   cls = 5'b0;
    endcase
  end

  // Retired/class counters and last-class LEDs, advanced on each enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cnt_q <= '0;
      cls_cnt_q <= '0;
      cls_q     <= '0;
    end else if (cpu_rst) begin
      ret_cnt_q <= '0;
      cls_cnt_q <= '0;
      cls_q     <= '0;
    end else if (cpu_clk_en) begin
      ret_cnt_q <= ret_cnt_q + 1'b1;
      cls_q     <= cls;
      for (int i = 0; i < 5; i++)
        if (cls[i]) cls_cnt_q[i] <= cls_cnt_q[i] + 1'b1;
    end
  end

  // Display source select
  always_comb begin
    seg_d = reg_data;
    case (sw_sel)
      3'd0:    seg_d = reg_data;
      3'd1:    seg_d = 32'(pc);
      3'd2:    seg_d = 32'(ret_cnt_q);
      default: seg_d = 32'(cls_cnt_q[sw_sel - 3'd3]);
    endcase
  end

  // Registered display value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_hex <= '0;
    else        seg_hex <= seg_d;
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl with a short debounce and a fast divider.
// A tiny core model advances pc by 4 on each enable.
module tb_cpu_debug_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sw_mode;
  logic [2:0]  sw_sel;
  logic [4:0]  sw_reg;
  logic        step_btn, cpu_rst_btn, bp_en;
  logic [8:0]  bp_addr, pc, pc_ld_val;
  logic        pc_ld;
  logic [31:0] instr, reg_data;
  logic [4:0]  reg_addr;
  logic        cpu_clk_en, cpu_rst;
  logic [31:0] seg_hex;
  logic [7:0]  led;
  logic [1:0]  dbg_state;
  int          tests = 0;
  int          fails = 0;
  int          en_total = 0;

  cpu_debug_ctrl #(.PC_WIDTH(9), .CNT_WIDTH(32), .DEBOUNCE_CYCLES(4), .DIV_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw_mode(sw_mode), .sw_sel(sw_sel), .sw_reg(sw_reg),
    .step_btn(step_btn), .cpu_rst_btn(cpu_rst_btn), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .instr(instr), .reg_data(reg_data), .reg_addr(reg_addr),
    .cpu_clk_en(cpu_clk_en), .cpu_rst(cpu_rst), .seg_hex(seg_hex), .led(led),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // core model: pc register advanced by each enable, loadable from the bench
  always @(posedge clk) begin
    if (pc_ld) pc <= pc_ld_val;
    else if (cpu_clk_en) pc <= pc + 9'd4;
    if (cpu_clk_en) en_total <= en_total + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic press_step();
    step_btn = 1'b1;
    repeat (6) @(negedge clk);
    step_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_mode = 2'b00; sw_sel = 3'd0; sw_reg = 5'h1A; step_btn = 1'b0;
    cpu_rst_btn = 1'b0; bp_en = 1'b0; bp_addr = 9'h0; instr = 32'hFC000000;
    reg_data = 32'hDEADBEEF; pc_ld = 1'b1; pc_ld_val = 9'h0;
    repeat (2) @(negedge clk);
    tests++; if (cpu_clk_en !== 1'b0) begin fails++; $display("FAIL rst_en got %b want 0", cpu_clk_en); end
    tests++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL rst_cpu_rst got %b want 0", cpu_rst); end
    tests++; if (seg_hex !== 32'h0) begin fails++; $display("FAIL rst_seg got %h want 0", seg_hex); end
    tests++; if (led !== 8'h80) begin fails++; $display("FAIL rst_led got %h want 80", led); end
    tests++; if (dbg_state !== 2'b00) begin fails++; $display("FAIL rst_state got %b want 00", dbg_state); end
    tests++; if (reg_addr !== 5'h1A) begin fails++; $display("FAIL reg_addr got %h want 1a", reg_addr); end
    pc_ld = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_step_debounce();
    int first, n;
    sw_mode = 2'b01; sw_sel = 3'd2;
    repeat (3) @(negedge clk);
    tests++; if (dbg_state !== 2'b01) begin fails++; $display("FAIL step_state got %b want 01", dbg_state); end
    first = -1; n = 0;
    step_btn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) step_btn = 1'b0;
      if (cpu_clk_en) begin n++; if (first < 0) first = c; end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    tests++; if (n !== 1) begin fails++; $display("FAIL step_count got %0d want 1", n); end
    tests++; if (first !== 7) begin fails++; $display("FAIL step_latency got cycle %0d want 7", first); end
    tests++; if (seg_hex !== 32'd1) begin fails++; $display("FAIL step_retired got %0d want 1", seg_hex); end
    n = 0;
    step_btn = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) step_btn = 1'b0;
      if (cpu_clk_en) n++;
      @(negedge clk);
    end
    tests++; if (n !== 0) begin fails++; $display("FAIL glitch_count got %0d want 0", n); end
  endtask

  task automatic test_breakpoint();
    int e0;
    pc_ld_val = 9'h0; pc_ld = 1'b1;
    @(negedge clk);
    pc_ld = 1'b0;
    bp_addr = 9'h010; bp_en = 1'b1;
    e0 = en_total;
    sw_mode = 2'b10;
    repeat (20) @(negedge clk);
    tests++; if (en_total - e0 !== 4) begin fails++; $display("FAIL bp_enables got %0d want 4", en_total - e0); end
    tests++; if (dbg_state !== 2'b11) begin fails++; $display("FAIL bp_state got %b want 11", dbg_state); end
    tests++; if (led[5] !== 1'b1) begin fails++; $display("FAIL bp_led got %b want 1", led[5]); end
    tests++; if (pc !== 9'h010) begin fails++; $display("FAIL bp_pc got %h want 010", pc); end
    e0 = en_total;
    press_step();
    tests++; if (en_total - e0 !== 1) begin fails++; $display("FAIL bp_step got %0d want 1", en_total - e0); end
    tests++; if (dbg_state !== 2'b11) begin fails++; $display("FAIL bp_step_state got %b want 11", dbg_state); end
  endtask

  task automatic test_bp_resume();
    int c;
    pc_ld_val = 9'h010; pc_ld = 1'b1;
    @(negedge clk);
    pc_ld = 1'b0;
    sw_mode = 2'b00;
    repeat (2) @(negedge clk);
    tests++; if (dbg_state !== 2'b00) begin fails++; $display("FAIL resume_halt got %b want 00", dbg_state); end
    sw_mode = 2'b10;
    c = 0;
    while (!cpu_clk_en && c < 10) begin @(negedge clk); c++; end
    tests++; if (cpu_clk_en !== 1'b1) begin fails++; $display("FAIL resume_en got %b want 1", cpu_clk_en); end
    tests++; if (pc !== 9'h010) begin fails++; $display("FAIL resume_pc got %h want 010", pc); end
    repeat (4) @(negedge clk);
    tests++; if (pc !== 9'h020) begin fails++; $display("FAIL resume_run_pc got %h want 020", pc); end
    tests++; if (dbg_state !== 2'b10) begin fails++; $display("FAIL resume_state got %b want 10", dbg_state); end
    sw_mode = 2'b00; bp_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_divided();
    int prev, n;
    prev = -1; n = 0;
    sw_mode = 2'b11;
    for (int c = 0; c < 40; c++) begin
      if (cpu_clk_en) begin
        if (prev >= 0) begin
          tests++;
          if (c - prev !== 8) begin fails++; $display("FAIL div_gap got %0d want 8", c - prev); end
        end
        prev = c; n++;
      end
      @(negedge clk);
    end
    tests++; if (n < 4 || n > 5) begin fails++; $display("FAIL div_count got %0d want 4..5", n); end
    sw_mode = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpu_rst();
    sw_mode = 2'b10; sw_sel = 3'd2;
    repeat (5) @(negedge clk);
    tests++; if (seg_hex === 32'd0) begin fails++; $display("FAIL crst_pre got %0d want nonzero", seg_hex); end
    cpu_rst_btn = 1'b1;
    tests++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL crst_c0 got %b want 0", cpu_rst); end
    @(negedge clk);
    tests++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL crst_c1 got %b want 0", cpu_rst); end
    @(negedge clk);
    tests++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL crst_c2 got %b want 1", cpu_rst); end
    tests++; if (cpu_clk_en !== 1'b0) begin fails++; $display("FAIL crst_en got %b want 0", cpu_clk_en); end
    @(negedge clk);
    sw_mode = 2'b00;
    tests++; if (dbg_state !== 2'b00) begin fails++; $display("FAIL crst_state got %b want 00", dbg_state); end
    repeat (2) @(negedge clk);
    cpu_rst_btn = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL crst_release got %b want 0", cpu_rst); end
    for (int s = 2; s < 8; s++) begin
      sw_sel = 3'(s);
      @(negedge clk);
      tests++; if (seg_hex !== 32'd0) begin fails++; $display("FAIL crst_cnt sel %0d got %0d want 0", s, seg_hex); end
    end
  endtask

  task automatic test_classes();
    logic [31:0] ins [6];
    logic [4:0]  exp [6];
    ins = '{32'h012A4020, 32'h8C080004, 32'hAC080004, 32'h11090003, 32'h08000010, 32'hFC000000};
    exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
    sw_mode = 2'b01;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      instr = ins[i];
      press_step();
      tests++; if (led[4:0] !== exp[i]) begin fails++; $display("FAIL class_led %0d got %b want %b", i, led[4:0], exp[i]); end
    end
    for (int s = 3; s < 8; s++) begin
      sw_sel = 3'(s);
      @(negedge clk);
      tests++; if (seg_hex !== 32'd1) begin fails++; $display("FAIL class_cnt sel %0d got %0d want 1", s, seg_hex); end
    end
    sw_sel = 3'd2;
    @(negedge clk);
    tests++; if (seg_hex !== 32'd6) begin fails++; $display("FAIL class_retired got %0d want 6", seg_hex); end
  endtask

  task automatic test_display();
    logic [8:0] p;
    sw_sel = 3'd0;
    @(negedge clk);
    tests++; if (seg_hex !== 32'hDEADBEEF) begin fails++; $display("FAIL disp_reg got %h want deadbeef", seg_hex); end
    p = pc;
    sw_sel = 3'd1;
    @(negedge clk);
    tests++; if (seg_hex !== {23'd0, p}) begin fails++; $display("FAIL disp_pc got %h want %h", seg_hex, {23'd0, p}); end
    sw_sel = 3'd2;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    step_btn = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (seg_hex !== 32'h0) begin fails++; $display("FAIL arst_seg got %h want 0", seg_hex); end
    tests++; if (led !== 8'h80) begin fails++; $display("FAIL arst_led got %h want 80", led); end
    tests++; if (dbg_state !== 2'b00) begin fails++; $display("FAIL arst_state got %b want 00", dbg_state); end
    tests++; if (cpu_clk_en !== 1'b0 || cpu_rst !== 1'b0) begin fails++; $display("FAIL arst_en got %b/%b want 0/0", cpu_clk_en, cpu_rst); end
    step_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_step_debounce();
    test_breakpoint();
    test_bp_resume();
    test_divided();
    test_cpu_rst();
    test_classes();
    test_display();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
